mod_busdec: RTL and testbench
=============================

// Module: mod_busdec
// PURPOSE
//  CPU-side memory-map decoder feeding all memory-mapped slaves (plpid, uart, ram, ...).
//  - Splits CPU I/D requests by address nibble [31:28] into per-slot enables with 28-bit slot-relative offsets.
//  - Muxes slave return data back to the CPU.
//  - Inserts per-slot data-side wait states, stalling the CPU through a stall handshake.
// PARAMETERS
//  NSLOT  4        number of mapped slots (1..16); slot k = addresses 0xk0000000..0xkFFFFFFF
//  WAIT   16'h0200 packed 4-bit data wait-state count per slot, slot k at WAIT[4k+3:4k] (default: slot 2 = 2)
// PORTS
//  clk      in   1         system clock
//  rst      in   1         synchronous active-high reset
//  ie       in   1         CPU instruction fetch enable
//  de       in   1         CPU data access enable
//  iaddr    in   32        CPU instruction address
//  daddr    in   32        CPU data address
//  drw      in   1         1 = data write, 0 = data read
//  din      in   32        CPU write data
//  iout     out  32        instruction data to CPU
//  dout     out  32        read data to CPU
//  stall    out  1         1 = CPU must hold de/daddr/drw/din
//  s_ie     out  NSLOT     per-slot instruction enable
//  s_de     out  NSLOT     per-slot data enable
//  s_iaddr  out  32        {4'h0, iaddr[27:0]}
//  s_daddr  out  32        {4'h0, data offset[27:0]}
//  s_drw    out  1         write strobe qualifier to slaves
//  s_din    out  32        write data to slaves
//  s_iout   in   NSLOT*32  slave instruction data, slot k at [32k+31:32k]
//  s_dout   in   NSLOT*32  slave read data, slot k at [32k+31:32k]
//  bus_err  out  1         sticky unmapped-access flag (BUSDEC_ERR_EN only, else tied 0)
//  err_addr out  32        address of first unmapped access (BUSDEC_ERR_EN only, else tied 0)
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
//  Reset values:
//   - state IDLE, stall 0, count 0, s_de 0, s_drw 0.
//   - bus_err 0, err_addr 0.
//  Instruction side: purely combinational, zero wait.
//   - s_ie[k] = ie & (iaddr[31:28]==k).
//   - iout = s_iout slot k; 0 if unmapped (k >= NSLOT) or ie=0.
//  Data FSM: IDLE, WAIT.
//   IDLE, de=1, mapped slot k:
//    - W = WAIT[4k+3:4k].
//    - W==0: single-cycle access, combinational like I-side.
//      s_de[k]=1, s_drw=drw, dout = s_dout slot k, stall=0.
//    - W>0: latch slot, offset, drw and din; count<=W; stall=1 same cycle (combinational); go to WAIT.
//   WAIT:
//    - s_de[latched]=1 every cycle; s_daddr, s_din from latches; s_drw=0 except the final cycle.
//    - Each cycle count<=count-1.
//    - When count==1 (final cycle): stall=0, s_drw=latched drw (single write strobe),
//      dout = s_dout of latched slot, next state IDLE.
//    - Total access = W+1 cycles; stall high for exactly W cycles.
//   dout is 0 in any cycle with no completing read.
//  Boundary conditions:
//   - de held high back-to-back: the next access is accepted in the cycle after the final cycle.
//   - CPU address/data changing during WAIT is ignored (latched values used).
//   - Unmapped data access (daddr[31:28] >= NSLOT): single cycle, no s_de, dout=0, stall=0.
//     Writes are dropped.
//   - ie and de to the same slot in one cycle: both enables asserted; slaves arbitrate internally.
//   - rst during WAIT: FSM to IDLE next edge, stall=0; the pending write is never strobed.
// CONFIGURATION
//  BUSDEC_ERR_EN defined:
//   - Unmapped I or D access sets bus_err=1 (sticky until rst).
//   - First such access captures its full address into err_addr; the D address wins if both occur in one cycle.
//  BUSDEC_ERR_EN undefined: bus_err and err_addr tied 0; no error registers.
// TESTING
//  1. Slot 0 read, WAIT 0: de=1, daddr=0x00000004, s_dout slot0=0x017d7840.
//     -> s_daddr=4, s_de=4'b0001, dout=0x017d7840 same cycle, stall never 1.
//  2. Slot 2 write, W=2: de=1, drw=1, daddr=0x20000010, din=0xDEADBEEF.
//     -> stall=1 for exactly 2 cycles; s_drw=1 only on cycle 3 with s_daddr=0x10, s_din=0xDEADBEEF.
//  3. Slot 2 read, W=2, daddr changed to 0x00000000 after accept.
//     -> s_de stays 4'b0100; dout = slot-2 data on cycle 3.
//  4. Unmapped daddr=0x70000000 write.
//     -> no s_de bit set, dout=0, stall=0.
//     With BUSDEC_ERR_EN: bus_err=1, err_addr=0x70000000; stays set after a later 0x80000000 access.
//  5. rst=1 on cycle 2 of a slot-2 write.
//     -> stall=0 next cycle, s_drw never asserted, state IDLE.
//  6. ie=1, iaddr=0x10000020 concurrent with slot-0 data read.
//     -> s_ie=4'b0010, s_iaddr=0x20, iout = slot-1 data; data path unaffected.

Source files
------------

// File: rtl/mod_busdec.sv
// -----------------------------------------------------------------------------
// mod_busdec -- CPU-side memory-map decoder.
//
// Splits CPU instruction/data requests by address nibble [31:28] into per-slot
// enables carrying 28-bit slot-relative offsets, muxes slave return data back
// to the CPU, and inserts per-slot data-side wait states by stalling the CPU.
//
// Optional feature macro: BUSDEC_ERR_EN
//   defined   : sticky bus_err flag plus capture of the first unmapped address
//   undefined : bus_err and err_addr tied to 0, no error registers
//
// Parameters
//   NSLOT  number of mapped slots (1..16); slot k = 0xk0000000..0xkFFFFFFF
//   WAIT   packed 4-bit data wait-state count per slot, slot k at [4k+3:4k]
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ie, iaddr, iout     CPU instruction fetch (zero wait)
//   de, daddr, drw, din CPU data access request; dout read data; stall hold
//   s_ie, s_iaddr       per-slot instruction enables and offset
//   s_de, s_daddr       per-slot data enables and offset
//   s_drw, s_din        write strobe qualifier and write data to slaves
//   s_iout, s_dout      slave instruction / read data, slot k at [32k+31:32k]
//   bus_err, err_addr   sticky unmapped-access flag and first faulting address
// -----------------------------------------------------------------------------
module mod_busdec #(
  parameter int                   NSLOT = 4,
  parameter logic [4*NSLOT-1:0]   WAIT  = 16'h0200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ie,
  input  logic                 de,
  input  logic [31:0]          iaddr,
  input  logic [31:0]          daddr,
  input  logic                 drw,
  input  logic [31:0]          din,
  output logic [31:0]          iout,
  output logic [31:0]          dout,
  output logic                 stall,
  output logic [NSLOT-1:0]     s_ie,
  output logic [NSLOT-1:0]     s_de,
  output logic [31:0]          s_iaddr,
  output logic [31:0]          s_daddr,
  output logic                 s_drw,
  output logic [31:0]          s_din,
  input  logic [NSLOT*32-1:0]  s_iout,
  input  logic [NSLOT*32-1:0]  s_dout,
  output logic                 bus_err,
  output logic [31:0]          err_addr
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state;
  logic [3:0]  count_q;
  logic [3:0]  slot_q;
  logic [27:0] off_q;
  logic        drw_q;
  logic [31:0] din_q;

  logic [3:0]  inib, dnib;
  logic        i_map, d_map;
  logic [3:0]  w_sel;
  logic        accept_wait;

  assign inib  = iaddr[31:28];
  assign dnib  = daddr[31:28];
  assign i_map = int'(inib) < NSLOT;
  assign d_map = int'(dnib) < NSLOT;

  // Wait-state count of the slot currently addressed by the data side.
  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NSLOT; k++) begin
      if (dnib == 4'(k)) w_sel = WAIT[4*k +: 4];
    end
  end

  // A mapped access to a slot with wait states starts a multi-cycle transfer.
  assign accept_wait = (state == ST_IDLE) && de && d_map && (w_sel != 4'd0);

  // Instruction side: purely combinational, zero wait.
  assign s_iaddr = {4'h0, iaddr[27:0]};

  always_comb begin
    s_ie = '0;
    iout = '0;
    for (int k = 0; k < NSLOT; k++) begin
      if (ie && inib == 4'(k)) begin
        s_ie[k] = 1'b1;
        iout    = s_iout[32*k +: 32];
      end
    end
  end

  // Data side outputs. In WAIT everything comes from the latched request so
  // CPU-side changes are ignored; the write strobe fires only on the final
  // cycle so each write reaches the slave exactly once.
  always_comb begin
    s_de    = '0;
    s_drw   = 1'b0;
    s_daddr = {4'h0, daddr[27:0]};
    s_din   = din;
    dout    = '0;
    stall   = 1'b0;
    if (state == ST_WAIT) begin
      s_daddr = {4'h0, off_q};
      s_din   = din_q;
      for (int k = 0; k < NSLOT; k++) begin
        if (slot_q == 4'(k)) begin
          s_de[k] = 1'b1;
          if (count_q == 4'd1 && !drw_q) dout = s_dout[32*k +: 32];
        end
      end
      if (count_q == 4'd1) s_drw = drw_q;
      else                 stall = 1'b1;
    end else if (de && d_map) begin
      if (w_sel == 4'd0) begin
        s_drw = drw;
        for (int k = 0; k < NSLOT; k++) begin
          if (dnib == 4'(k)) begin
            s_de[k] = 1'b1;
            if (!drw) dout = s_dout[32*k +: 32];
          end
        end
      end else begin
        // Accept cycle of a waited access: hold the CPU immediately.
        stall = 1'b1;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_wait) begin
            state   <= ST_WAIT;
            count_q <= w_sel;
          end
        end
        ST_WAIT: begin
          count_q <= count_q - 4'd1;
          if (count_q == 4'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the request latches carry no reset; they are only observed while in
  // WAIT, which can only be entered after they have been loaded.
  always_ff @(posedge clk) begin
    if (accept_wait) begin
      slot_q <= dnib;
      off_q  <= daddr[27:0];
      drw_q  <= drw;
      din_q  <= din;
    end
  end

`ifdef BUSDEC_ERR_EN
  logic d_unmap, i_unmap;

  // Data requests are only decoded in IDLE; during WAIT de is ignored.
  assign d_unmap = (state == ST_IDLE) && de && !d_map;
  assign i_unmap = ie && !i_map;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else if (!bus_err && (d_unmap || i_unmap)) begin
      bus_err  <= 1'b1;
      err_addr <= d_unmap ? daddr : iaddr;
    end
  end
`else
  assign bus_err  = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_mod_busdec.sv
// -----------------------------------------------------------------------------
// tb_mod_busdec -- self-checking bench for mod_busdec (default parameters:
// NSLOT=4, slot 2 has two data wait states, all other slots zero).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mod_busdec;

  localparam int NSLOT = 4;
  localparam int WAITS [NSLOT] = '{0, 0, 2, 0};

  logic               clk = 1'b0;
  logic               rst;
  logic               ie, de, drw;
  logic [31:0]        iaddr, daddr, din;
  logic [31:0]        iout, dout;
  logic               stall;
  logic [NSLOT-1:0]   s_ie, s_de;
  logic [31:0]        s_iaddr, s_daddr, s_din;
  logic               s_drw;
  logic [NSLOT*32-1:0] s_iout, s_dout;
  logic               bus_err;
  logic [31:0]        err_addr;

  int checks = 0;
  int errors = 0;

  mod_busdec dut (
    .clk(clk), .rst(rst), .ie(ie), .de(de), .iaddr(iaddr), .daddr(daddr),
    .drw(drw), .din(din), .iout(iout), .dout(dout), .stall(stall),
    .s_ie(s_ie), .s_de(s_de), .s_iaddr(s_iaddr), .s_daddr(s_daddr),
    .s_drw(s_drw), .s_din(s_din), .s_iout(s_iout), .s_dout(s_dout),
    .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  typedef struct {
    logic        ie, de, drw;
    logic [31:0] iaddr, daddr, din;
    logic [3:0]  e_sie, e_sde;
    logic        e_sdrw;
    logic [31:0] e_dout, e_iout, e_daddr;
  } vec_t;

  vec_t vecs [9];

  // Random-phase reference model: one outstanding access described by the
  // number of cycles left until it completes.
  int          rem;
  logic [3:0]  m_slot;
  logic [27:0] m_off;
  logic        m_drw;
  logic [31:0] m_din;
  logic        m_err;
  logic [31:0] m_eaddr;

  initial begin
    rst = 1'b1; ie = 0; de = 0; drw = 0;
    iaddr = '0; daddr = '0; din = '0;
    s_dout = {32'h33333333, 32'h22222222, 32'h11111111, 32'h017d7840};
    s_iout = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};

    vecs[0] = '{0,1,0, 32'h0, 32'h00000004, 32'h0,      4'b0000,4'b0001,0, 32'h017d7840, 32'h0, 32'h00000004};
    vecs[1] = '{0,1,0, 32'h0, 32'h12345678, 32'h0,      4'b0000,4'b0010,0, 32'h11111111, 32'h0, 32'h02345678};
    vecs[2] = '{0,1,1, 32'h0, 32'h300000FC, 32'hCAFEF00D,4'b0000,4'b1000,1, 32'h0,       32'h0, 32'h000000FC};
    vecs[3] = '{0,1,1, 32'h0, 32'h70000000, 32'h1,      4'b0000,4'b0000,0, 32'h0,        32'h0, 32'h00000000};
    vecs[4] = '{1,1,0, 32'h10000020, 32'h0, 32'h0,      4'b0010,4'b0001,0, 32'h017d7840, 32'hA1A1A1A1, 32'h0};
    vecs[5] = '{0,0,0, 32'h10000020, 32'h0, 32'h0,      4'b0000,4'b0000,0, 32'h0,        32'h0, 32'h0};
    vecs[6] = '{1,0,0, 32'hF0000000, 32'h0, 32'h0,      4'b0000,4'b0000,0, 32'h0,        32'h0, 32'h0};
    vecs[7] = '{1,1,0, 32'h30000100, 32'h30000200, 32'h0,4'b1000,4'b1000,0, 32'h33333333, 32'hA3A3A3A3, 32'h00000200};
    vecs[8] = '{1,0,0, 32'h20000000, 32'h0, 32'h0,      4'b0100,4'b0000,0, 32'h0,        32'hA2A2A2A2, 32'h0};

    // ---- reset state ----
    repeat (3) step();
    rst = 1'b0;
    settle();
    check("rst_stall", stall, 0);
    check("rst_s_de", s_de, 0);
    check("rst_s_drw", s_drw, 0);
    check("rst_dout", dout, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_err_addr", err_addr, 0);

    // ---- single-cycle table ----
    for (int i = 0; i < 9; i++) begin
      step();
      ie = vecs[i].ie; de = vecs[i].de; drw = vecs[i].drw;
      iaddr = vecs[i].iaddr; daddr = vecs[i].daddr; din = vecs[i].din;
      settle();
      check($sformatf("v%0d_s_ie", i), s_ie, vecs[i].e_sie);
      check($sformatf("v%0d_iout", i), iout, vecs[i].e_iout);
      check($sformatf("v%0d_s_iaddr", i), s_iaddr, {4'h0, vecs[i].iaddr[27:0]});
      check($sformatf("v%0d_s_de", i), s_de, vecs[i].e_sde);
      check($sformatf("v%0d_s_drw", i), s_drw, vecs[i].e_sdrw);
      check($sformatf("v%0d_stall", i), stall, 0);
      check($sformatf("v%0d_dout", i), dout, vecs[i].e_dout);
      check($sformatf("v%0d_s_daddr", i), s_daddr, vecs[i].e_daddr);
      if (vecs[i].e_sde != 0) check($sformatf("v%0d_s_din", i), s_din, vecs[i].din);
    end

    // ---- error capture: first unmapped access was the 0x70000000 write ----
    step();
    ie = 0; de = 1; drw = 0; daddr = 32'h80000000;
    settle();
    check("unmap8_s_de", s_de, 0);
    check("unmap8_stall", stall, 0);
    step();
    de = 0;
    settle();
`ifdef BUSDEC_ERR_EN
    check("err_sticky", bus_err, 1);
    check("err_addr_first", err_addr, 32'h70000000);
`else
    check("err_tied", bus_err, 0);
    check("err_addr_tied", err_addr, 0);
`endif

    // ---- slot-2 write, two wait states ----
    step();
    de = 1; drw = 1; daddr = 32'h20000010; din = 32'hDEADBEEF;
    settle();
    check("w2_c1_stall", stall, 1);
    check("w2_c1_s_drw", s_drw, 0);
    step();
    settle();
    check("w2_c2_stall", stall, 1);
    check("w2_c2_s_drw", s_drw, 0);
    check("w2_c2_s_de", s_de, 4'b0100);
    step();
    settle();
    check("w2_c3_stall", stall, 0);
    check("w2_c3_s_drw", s_drw, 1);
    check("w2_c3_s_de", s_de, 4'b0100);
    check("w2_c3_s_daddr", s_daddr, 32'h10);
    check("w2_c3_s_din", s_din, 32'hDEADBEEF);
    check("w2_c3_dout", dout, 0);
    step();
    de = 0; drw = 0;
    settle();
    check("w2_c4_s_de", s_de, 0);
    check("w2_c4_s_drw", s_drw, 0);

    // ---- slot-2 read, CPU address changes during WAIT, then back-to-back ----
    step();
    de = 1; drw = 0; daddr = 32'h20000008;
    settle();
    check("r2_c1_stall", stall, 1);
    check("r2_c1_dout", dout, 0);
    step();
    daddr = 32'h00000000; drw = 0;
    settle();
    check("r2_c2_s_de", s_de, 4'b0100);
    check("r2_c2_stall", stall, 1);
    check("r2_c2_dout", dout, 0);
    check("r2_c2_s_daddr", s_daddr, 32'h8);
    step();
    settle();
    check("r2_c3_s_de", s_de, 4'b0100);
    check("r2_c3_stall", stall, 0);
    check("r2_c3_dout", dout, 32'h22222222);
    check("r2_c3_s_drw", s_drw, 0);
    step();
    settle();
    check("b2b_s_de", s_de, 4'b0001);
    check("b2b_dout", dout, 32'h017d7840);
    check("b2b_stall", stall, 0);
    step();
    de = 0;

    // ---- reset in the middle of a waited write ----
    step();
    de = 1; drw = 1; daddr = 32'h20000040; din = 32'h12345678;
    settle();
    check("rw_c1_stall", stall, 1);
    step();
    rst = 1; de = 0; drw = 0;
    settle();
    check("rw_c2_s_drw", s_drw, 0);
    step();
    rst = 0;
    settle();
    check("rw_c3_stall", stall, 0);
    check("rw_c3_s_drw", s_drw, 0);
    check("rw_c3_s_de", s_de, 0);
    step();
    settle();
    check("rw_c4_s_drw", s_drw, 0);
    check("rw_c4_stall", stall, 0);
    check("rw_err_clr", bus_err, 0);

    // ---- randomized traffic against the reference model ----
    rem = 0; m_err = 0; m_eaddr = '0;
    m_slot = '0; m_off = '0; m_drw = 0; m_din = '0;
    for (int c = 0; c < 400; c++) begin
      logic [3:0]  dn, in;
      logic        mapped, accept, d_unmap, i_unmap, chk_sde, chk_addr;
      logic [3:0]  e_sde, e_sie;
      logic        e_stall, e_sdrw;
      logic [31:0] e_dout, e_iout, e_daddr, e_din;

      step();
      ie    = 1'($urandom_range(0, 1));
      de    = ($urandom_range(0, 9) < 6);
      drw   = 1'($urandom_range(0, 1));
      iaddr = {4'($urandom_range(0, 7)), 28'($urandom)};
      daddr = {4'($urandom_range(0, 5)), 28'($urandom)};
      din   = $urandom;
      s_dout = {$urandom, $urandom, $urandom, $urandom};
      s_iout = {$urandom, $urandom, $urandom, $urandom};

      in = iaddr[31:28];
      dn = daddr[31:28];
      mapped = int'(dn) < NSLOT;
      e_sie  = (ie && int'(in) < NSLOT) ? 4'(1 << in) : 4'b0;
      e_iout = (ie && int'(in) < NSLOT) ? s_iout[32*in +: 32] : 32'h0;

      accept = 0; d_unmap = 0; chk_sde = 1; chk_addr = 0;
      e_sde = 0; e_sdrw = 0; e_dout = 0; e_stall = 0; e_daddr = 0; e_din = 0;
      if (rem > 0) begin
        e_sde = 4'(1 << m_slot); chk_addr = 1;
        e_daddr = {4'h0, m_off}; e_din = m_din;
        if (rem == 1) begin
          e_sdrw = m_drw;
          e_dout = m_drw ? 32'h0 : s_dout[32*m_slot +: 32];
        end else begin
          e_stall = 1;
        end
      end else if (de && mapped) begin
        if (WAITS[dn] == 0) begin
          e_sde = 4'(1 << dn); e_sdrw = drw; chk_addr = 1;
          e_dout = drw ? 32'h0 : s_dout[32*dn +: 32];
          e_daddr = {4'h0, daddr[27:0]}; e_din = din;
        end else begin
          accept = 1; e_stall = 1; chk_sde = 0;
        end
      end else begin
        d_unmap = de && !mapped;
      end
      i_unmap = ie && int'(in) >= NSLOT;

      settle();
      check("rnd_s_ie", s_ie, e_sie);
      check("rnd_iout", iout, e_iout);
      check("rnd_stall", stall, e_stall);
      check("rnd_s_drw", s_drw, e_sdrw);
      check("rnd_dout", dout, e_dout);
      if (chk_sde) check("rnd_s_de", s_de, e_sde);
      if (chk_addr) begin
        check("rnd_s_daddr", s_daddr, e_daddr);
        check("rnd_s_din", s_din, e_din);
      end
`ifdef BUSDEC_ERR_EN
      check("rnd_bus_err", bus_err, m_err);
      check("rnd_err_addr", err_addr, m_eaddr);
`else
      check("rnd_bus_err", bus_err, 0);
      check("rnd_err_addr", err_addr, 0);
`endif

      // advance the model to the next edge
      if (rem > 0) rem--;
      else if (accept) begin
        rem = WAITS[dn]; m_slot = dn; m_off = daddr[27:0];
        m_drw = drw; m_din = din;
      end
      if (!m_err && (d_unmap || i_unmap)) begin
        m_err = 1;
        m_eaddr = d_unmap ? daddr : iaddr;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
